// File: rtl/fifo_pkg.sv
// Shared constants and width helpers for the flop-based FIFO.
// FIFO_ERR_CNT_EN (optional macro) enables the drop/ignore error counters.
package fifo_pkg;

  localparam int unsigned ERR_CNT_W = 8;

  // Pointer width; a floor of 1 keeps the index legal for tiny depths.
  function automatic int unsigned ptr_w(input int unsigned depth);
    return (depth < 2) ? 32'd1 : 32'($clog2(depth));
  endfunction

  // Occupancy width: must hold the value DEPTH itself.
  function automatic int unsigned cnt_w(input int unsigned depth);
    return 32'($clog2(depth + 1));
  endfunction

endpackage

// File: rtl/fifo_ptr_ctl.sv
// Pointer, occupancy, accept and status-flag control for fifo_flops_param.
// FIFO_ERR_CNT_EN adds saturating drop/ignore counters.
module fifo_ptr_ctl
  import fifo_pkg::*;
#(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned AF_THR = DEPTH - 2,
  parameter int unsigned AE_THR = 2,
  localparam int unsigned PW    = ptr_w(DEPTH),
  localparam int unsigned CW    = cnt_w(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  logic                 pop,
  input  logic                 clr_err,
  output logic                 wr_en_c,
  output logic [PW-1:0]        wr_ptr,
  output logic [PW-1:0]        rd_ptr,
  output logic [CW-1:0]        count,
  output logic                 pndng,
  output logic                 full,
  output logic                 almost_full,
  output logic                 almost_empty,
  output logic                 overflow,
`ifdef FIFO_ERR_CNT_EN
  output logic [ERR_CNT_W-1:0] drop_cnt,
  output logic [ERR_CNT_W-1:0] ign_cnt,
`endif
  output logic                 underflow
);

  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);

  logic push_ok_c;
  logic pop_ok_c;
  logic drop_c;
  logic ign_c;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PW'(1);
  endfunction

  // A pop frees a slot in the same cycle, so push is allowed when full with pop.
  always_comb begin
    push_ok_c = push & (~full | pop);
    pop_ok_c  = pop & pndng;
    drop_c    = push & full & ~pop;
    ign_c     = pop & ~pndng;
  end

  assign wr_en_c = push_ok_c;

  always_comb begin
    pndng        = (count != '0);
    full         = (count == CW'(DEPTH));
    almost_full  = (32'(count) >= AF_THR);
    almost_empty = (32'(count) <= AE_THR);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok_c) wr_ptr <= ptr_inc(wr_ptr);
      if (pop_ok_c)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push_ok_c, pop_ok_c})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Sticky errors: a new event in the clearing cycle wins over clr_err.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= (overflow  & ~clr_err) | drop_c;
      underflow <= (underflow & ~clr_err) | ign_c;
    end
  end

`ifdef FIFO_ERR_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      drop_cnt <= '0;
      ign_cnt  <= '0;
    end else begin
      if (clr_err)
        drop_cnt <= ERR_CNT_W'(drop_c);
      else if (drop_c && (drop_cnt != '1))
        drop_cnt <= drop_cnt + ERR_CNT_W'(1);

      if (clr_err)
        ign_cnt <= ERR_CNT_W'(ign_c);
      else if (ign_c && (ign_cnt != '1))
        ign_cnt <= ign_cnt + ERR_CNT_W'(1);
    end
  end
`endif

endmodule

// File: rtl/fifo_flops_param.sv
// Flop-array FIFO with first-word fall-through output and sticky error flags.
// FIFO_ERR_CNT_EN adds drop_cnt/ign_cnt outputs.
module fifo_flops_param
  import fifo_pkg::*;
#(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned BITS   = 16,
  parameter int unsigned AF_THR = DEPTH - 2,
  parameter int unsigned AE_THR = 2,
  localparam int unsigned PW    = ptr_w(DEPTH),
  localparam int unsigned CW    = cnt_w(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [BITS-1:0]      Din,
  input  logic                 push,
  input  logic                 pop,
  input  logic                 clr_err,
  output logic [BITS-1:0]      Dout,
  output logic                 pndng,
  output logic                 full,
  output logic [CW-1:0]        count,
  output logic                 almost_full,
  output logic                 almost_empty,
  output logic                 overflow,
`ifdef FIFO_ERR_CNT_EN
  output logic [ERR_CNT_W-1:0] drop_cnt,
  output logic [ERR_CNT_W-1:0] ign_cnt,
`endif
  output logic                 underflow
);

  logic [BITS-1:0] mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic            wr_en_c;

  fifo_ptr_ctl #(
    .DEPTH  (DEPTH),
    .AF_THR (AF_THR),
    .AE_THR (AE_THR)
  ) u_ctl (
    .clk          (clk),
    .rst          (rst),
    .push         (push),
    .pop          (pop),
    .clr_err      (clr_err),
    .wr_en_c      (wr_en_c),
    .wr_ptr       (wr_ptr),
    .rd_ptr       (rd_ptr),
    .count        (count),
    .pndng        (pndng),
    .full         (full),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .overflow     (overflow),
`ifdef FIFO_ERR_CNT_EN
    .drop_cnt     (drop_cnt),
    .ign_cnt      (ign_cnt),
`endif
    .underflow    (underflow)
  );

  // Array is cleared on reset so Dout reads 0 until the first write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else if (wr_en_c) begin
      mem[wr_ptr] <= Din;
    end
  end

  assign Dout = mem[rd_ptr];

endmodule

// File: tb/tb_fifo_flops_param.sv
// Directed self-checking bench for fifo_flops_param at default parameters.
module tb_fifo_flops_param;
  import fifo_pkg::*;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned BITS  = 16;
  localparam int unsigned CW    = cnt_w(DEPTH);

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [BITS-1:0] Din = '0;
  logic            push = 1'b0;
  logic            pop = 1'b0;
  logic            clr_err = 1'b0;
  logic [BITS-1:0] Dout;
  logic            pndng, full, almost_full, almost_empty, overflow, underflow;
  logic [CW-1:0]   count;
`ifdef FIFO_ERR_CNT_EN
  logic [ERR_CNT_W-1:0] drop_cnt, ign_cnt;
`endif

  int total = 0;
  int bad   = 0;

  fifo_flops_param dut (
    .clk          (clk),
    .rst          (rst),
    .Din          (Din),
    .push         (push),
    .pop          (pop),
    .clr_err      (clr_err),
    .Dout         (Dout),
    .pndng        (pndng),
    .full         (full),
    .count        (count),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .overflow     (overflow),
`ifdef FIFO_ERR_CNT_EN
    .drop_cnt     (drop_cnt),
    .ign_cnt      (ign_cnt),
`endif
    .underflow    (underflow)
  );

  always #5 clk = ~clk;

  task automatic op(input logic p, input logic q, input int d, input logic c);
    push = p; pop = q; Din = BITS'(d); clr_err = c;
    @(posedge clk); #1;
    push = 1'b0; pop = 1'b0; clr_err = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #3;
    total++; if (count !== '0) begin bad++; $display("FAIL rst_count got=%0d exp=0", count); end
    total++; if (pndng !== 1'b0) begin bad++; $display("FAIL rst_pndng got=%b exp=0", pndng); end
    total++; if (full !== 1'b0) begin bad++; $display("FAIL rst_full got=%b exp=0", full); end
    total++; if (almost_empty !== 1'b1) begin bad++; $display("FAIL rst_ae got=%b exp=1", almost_empty); end
    total++; if (almost_full !== 1'b0) begin bad++; $display("FAIL rst_af got=%b exp=0", almost_full); end
    total++; if ({overflow, underflow} !== 2'b00) begin bad++; $display("FAIL rst_err got=%b%b exp=00", overflow, underflow); end
    total++; if (Dout !== '0) begin bad++; $display("FAIL rst_dout got=%0h exp=0", Dout); end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < 16; i++) begin
      op(1'b1, 1'b0, i, 1'b0);
      total++; if (count !== CW'(i + 1)) begin bad++; $display("FAIL fill_count[%0d] got=%0d exp=%0d", i, count, i + 1); end
    end
    total++; if (full !== 1'b1) begin bad++; $display("FAIL fill_full got=%b exp=1", full); end
    for (int i = 0; i < 16; i++) begin
      total++; if (Dout !== BITS'(i)) begin bad++; $display("FAIL drain_dout[%0d] got=%0d exp=%0d", i, Dout, i); end
      op(1'b0, 1'b1, 0, 1'b0);
    end
    total++; if (pndng !== 1'b0 || count !== '0) begin bad++; $display("FAIL drain_empty got=%b/%0d exp=0/0", pndng, count); end
    total++; if ({overflow, underflow} !== 2'b00) begin bad++; $display("FAIL drain_err got=%b%b exp=00", overflow, underflow); end
  endtask

  task automatic test_overflow();
    for (int k = 1; k <= 40; k++) begin
      op(1'b1, 1'b0, k - 1, 1'b0);
      total++; if (overflow !== (k >= 17)) begin bad++; $display("FAIL ovf_flag[%0d] got=%b exp=%b", k, overflow, k >= 17); end
    end
    total++; if (count !== CW'(16)) begin bad++; $display("FAIL ovf_count got=%0d exp=16", count); end
`ifdef FIFO_ERR_CNT_EN
    total++; if (drop_cnt !== 8'd24) begin bad++; $display("FAIL ovf_drop_cnt got=%0d exp=24", drop_cnt); end
`endif
    for (int i = 0; i < 16; i++) begin
      total++; if (Dout !== BITS'(i)) begin bad++; $display("FAIL ovf_dout[%0d] got=%0d exp=%0d", i, Dout, i); end
      op(1'b0, 1'b1, 0, 1'b0);
    end
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%b exp=1", overflow); end
    op(1'b0, 1'b0, 0, 1'b1);
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_clear got=%b exp=0", overflow); end
`ifdef FIFO_ERR_CNT_EN
    total++; if (drop_cnt !== 8'd0) begin bad++; $display("FAIL ovf_drop_clr got=%0d exp=0", drop_cnt); end
`endif
  endtask

  task automatic test_underflow();
    for (int k = 0; k < 20; k++) begin
      op(1'b0, 1'b1, 0, 1'b0);
      total++; if (count !== '0 || underflow !== 1'b1) begin bad++; $display("FAIL udf_pop[%0d] got=%0d/%b exp=0/1", k, count, underflow); end
    end
`ifdef FIFO_ERR_CNT_EN
    total++; if (ign_cnt !== 8'd20) begin bad++; $display("FAIL udf_ign_cnt got=%0d exp=20", ign_cnt); end
`endif
    op(1'b0, 1'b1, 0, 1'b1);
    total++; if (underflow !== 1'b1) begin bad++; $display("FAIL udf_clr_coincide got=%b exp=1", underflow); end
    op(1'b0, 1'b0, 0, 1'b1);
    total++; if (underflow !== 1'b0) begin bad++; $display("FAIL udf_clear got=%b exp=0", underflow); end
`ifdef FIFO_ERR_CNT_EN
    total++; if (ign_cnt !== 8'd0) begin bad++; $display("FAIL udf_ign_clr got=%0d exp=0", ign_cnt); end
`endif
  endtask

  task automatic test_simul();
    for (int i = 0; i < 5; i++) op(1'b1, 1'b0, 100 + i, 1'b0);
    for (int i = 0; i < 3; i++) begin
      op(1'b1, 1'b1, 105 + i, 1'b0);
      total++; if (count !== CW'(5)) begin bad++; $display("FAIL sim_count5[%0d] got=%0d exp=5", i, count); end
    end
    for (int i = 0; i < 11; i++) op(1'b1, 1'b0, 108 + i, 1'b0);
    total++; if (count !== CW'(16)) begin bad++; $display("FAIL sim_fill got=%0d exp=16", count); end
    for (int i = 0; i < 2; i++) begin
      op(1'b1, 1'b1, 119 + i, 1'b0);
      total++; if (count !== CW'(16) || overflow !== 1'b0) begin bad++; $display("FAIL sim_full[%0d] got=%0d/%b exp=16/0", i, count, overflow); end
    end
    for (int i = 0; i < 16; i++) begin
      total++; if (Dout !== BITS'(105 + i)) begin bad++; $display("FAIL sim_order[%0d] got=%0d exp=%0d", i, Dout, 105 + i); end
      op(1'b0, 1'b1, 0, 1'b0);
    end
    op(1'b1, 1'b1, 55, 1'b0);
    total++; if (count !== CW'(1) || underflow !== 1'b1) begin bad++; $display("FAIL sim_empty got=%0d/%b exp=1/1", count, underflow); end
    total++; if (Dout !== BITS'(55)) begin bad++; $display("FAIL sim_empty_dout got=%0d exp=55", Dout); end
    op(1'b0, 1'b1, 0, 1'b1);
    total++; if (count !== '0 || underflow !== 1'b0) begin bad++; $display("FAIL sim_recover got=%0d/%b exp=0/0", count, underflow); end
  endtask

  task automatic test_interleave();
    for (int i = 0; i < 17; i++) begin
      op(1'b1, 1'b0, 300 + 7 * i, 1'b0);
      total++; if (count !== CW'(1) || Dout !== BITS'(300 + 7 * i)) begin bad++; $display("FAIL il_push[%0d] got=%0d/%0d exp=1/%0d", i, count, Dout, 300 + 7 * i); end
      op(1'b0, 1'b1, 0, 1'b0);
      total++; if (count !== '0) begin bad++; $display("FAIL il_pop[%0d] got=%0d exp=0", i, count); end
    end
    total++; if ({overflow, underflow} !== 2'b00) begin bad++; $display("FAIL il_err got=%b%b exp=00", overflow, underflow); end
  endtask

  task automatic test_wrap_thresh();
    test_reset();
    for (int k = 1; k <= 12; k++) begin
      op(1'b1, 1'b0, 200 + k - 1, 1'b0);
      total++; if (almost_empty !== (k <= 2)) begin bad++; $display("FAIL wt_ae[%0d] got=%b exp=%b", k, almost_empty, k <= 2); end
    end
    for (int k = 0; k < 10; k++) op(1'b0, 1'b1, 0, 1'b0);
    total++; if (count !== CW'(2) || Dout !== BITS'(210)) begin bad++; $display("FAIL wt_mid got=%0d/%0d exp=2/210", count, Dout); end
    for (int j = 1; j <= 14; j++) begin
      op(1'b1, 1'b0, 400 + j, 1'b0);
      total++; if (almost_full !== (j + 2 >= 14)) begin bad++; $display("FAIL wt_af[%0d] got=%b exp=%b", j, almost_full, j + 2 >= 14); end
    end
    total++; if (count !== CW'(16) || full !== 1'b1) begin bad++; $display("FAIL wt_full got=%0d/%b exp=16/1", count, full); end
    total++; if (Dout !== BITS'(210)) begin bad++; $display("FAIL wt_head got=%0d exp=210", Dout); end
    push = 1'b1; Din = BITS'(9);
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    total++; if (count !== '0 || pndng !== 1'b0 || full !== 1'b0) begin bad++; $display("FAIL wt_rst_state got=%0d/%b/%b exp=0/0/0", count, pndng, full); end
    total++; if (Dout !== '0 || almost_empty !== 1'b1 || overflow !== 1'b0) begin bad++; $display("FAIL wt_rst_out got=%0d/%b/%b exp=0/1/0", Dout, almost_empty, overflow); end
    push = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    op(1'b1, 1'b0, 77, 1'b0);
    total++; if (Dout !== BITS'(77) || count !== CW'(1)) begin bad++; $display("FAIL wt_after_rst got=%0d/%0d exp=77/1", Dout, count); end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_overflow();
    test_underflow();
    test_simul();
    test_interleave();
    test_wrap_thresh();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fifo_flops_param.md
FIFO_FLOPS_PARAM -- requirements
Module: fifo_flops_param

Interface
REQ-001 Parameter DEPTH, default 16: number of entries; SHALL be legal for any value >= 2, not only powers of two.
REQ-002 Parameter BITS, default 16: data word width.
REQ-003 Parameter AF_THR, default DEPTH-2: almost-full threshold, in entries.
REQ-004 Parameter AE_THR, default 2: almost-empty threshold, in entries.
REQ-005 clk  in  1: single clock; all state SHALL update on its rising edge.
REQ-006 rst  in  1: asynchronous, active-low reset; assertion SHALL clear state immediately, and release SHALL be sampled on clk.
REQ-007 Din  in  BITS: write data.
REQ-008 push  in  1: write request.
REQ-009 pop  in  1: read request.
REQ-010 clr_err  in  1: synchronous clear of the sticky error flags.
REQ-011 Dout  out  BITS: head-of-FIFO word (first-word fall-through).
REQ-012 pndng  out  1: FIFO holds at least one entry.
REQ-013 full  out  1: count == DEPTH.
REQ-014 count  out  $clog2(DEPTH+1): current occupancy.
REQ-015 almost_full  out  1: count >= AF_THR.
REQ-016 almost_empty  out  1: count <= AE_THR.
REQ-017 overflow  out  1: sticky flag; a push was dropped.
REQ-018 underflow  out  1: sticky flag; a pop was ignored.

Function
REQ-019 Storage SHALL be a flop array of DEPTH x BITS words with write and read pointers of width $clog2(DEPTH).
REQ-020 Each pointer SHALL advance by 1 per accepted operation and wrap from DEPTH-1 to 0.
REQ-021 A push SHALL be accepted when full=0, or when full=1 and pop=1 in the same cycle.
REQ-022 An accepted push SHALL write Din at the write pointer on the edge.
REQ-023 A pop SHALL be accepted only when pndng=1; the read pointer SHALL advance on the edge.
REQ-024 Dout SHALL be combinational from the read pointer: valid whenever pndng=1, and holding the last array word at the read pointer when pndng=0.
REQ-025 Simultaneous accepted push and pop SHALL leave count unchanged and advance both pointers.
REQ-026 Push and pop together while empty: the push SHALL be accepted, the pop ignored, underflow set, and count becomes 1 (no bypass).
REQ-027 Push while full without pop: Din SHALL be dropped, state unchanged, and overflow set on the next edge.
REQ-028 Pop while empty: pointers and count SHALL be unchanged, and underflow set on the next edge.
REQ-029 overflow and underflow SHALL hold until clr_err=1 or reset.
REQ-030 If clr_err coincides with a new error event, the flag SHALL remain set.
REQ-031 pndng, full, almost_full and almost_empty SHALL be decoded combinationally from the registered count.

Reset
REQ-032 While rst=0, the pointers, count, overflow and underflow SHALL be 0.
REQ-033 While rst=0, pndng=0, full=0, almost_empty=1 and almost_full=(AF_THR==0).
REQ-034 Dout after reset SHALL be 0; the array SHALL be cleared on reset.
REQ-035 Reset asserted mid-operation SHALL discard all contents; the first push after release SHALL appear on Dout the cycle after it is accepted.

Configuration
REQ-036 Macro FIFO_ERR_CNT_EN, when defined, SHALL add outputs drop_cnt and ign_cnt (ERR_CNT_W bits each).
REQ-037 drop_cnt SHALL count dropped pushes and ign_cnt SHALL count ignored pops; both SHALL saturate at all-ones and clear on reset or clr_err.
REQ-038 Without FIFO_ERR_CNT_EN, these ports and counters SHALL not exist, and all other behaviour SHALL be identical.

Structure
REQ-039 Package fifo_pkg SHALL hold ERR_CNT_W (=8) and the count/pointer width helper functions.
REQ-040 Sub-module fifo_ptr_ctl SHALL own the pointers, count, accept logic and flags; the top level SHALL own the array and the Dout mux.

Verification
REQ-041 Fill/drain: 16 pushes of 0..15 then 16 pops -> full=1 after the 16th push, Dout sequence 0..15, then pndng=0 and count=0.
REQ-042 Overflow: 40 pushes of 0..39 into an empty FIFO -> contents 0..15, overflow=1 from the 17th push, and with FIFO_ERR_CNT_EN drop_cnt=24.
REQ-043 Underflow: 20 pops on an empty FIFO -> count stays 0 and underflow=1; clr_err -> underflow=0; with FIFO_ERR_CNT_EN ign_cnt=20.
REQ-044 Simultaneous push/pop: pushes with a pop in the same cycle when count=5, then when full -> count stays 5, then stays 16; overflow stays 0; FIFO order is preserved.
REQ-045 Interleaved: alternating single push and pop for 17 words -> count alternates 1/0, Dout equals each pushed word, no flags set.
REQ-046 Wrap and thresholds: 12 pushes, 10 pops, then 14 pushes -> pointers wrap, count=16, almost_full rises at 14, almost_empty falls at 3, rst=0 mid-sequence clears everything.
